// File: rtl/clock_reset_sequencer.sv
// -----------------------------------------------------------------------------
// clock_reset_sequencer
//
// Holds every downstream clock domain in reset until the PLL lock indication
// has been synchronized and seen stable, then releases the domain resets one
// at a time (domain 0 first) with a fixed gap between releases.  Loss of lock
// or a software reset request re-asserts all domain resets together.
//
// Ports:
//   clk           free-running reference clock
//   rstnn         asynchronous active-low reset
//   pll_locked    PLL lock indication, asynchronous to clk
//   sw_reset_req  level request for a full domain reset (clk-synchronous)
//   domain_rstnn  per-domain active-low resets, registered
//   all_released  high while in RUN, registered
//   seq_state     current FSM state encoding (debug)
//   lock_loss_cnt saturating count of lock-loss events
//
// Optional build macro:
//   CLOCK_RESET_SEQUENCER_LOCK_LOSS_COUNTER_EN
//     defined   : lock_loss_cnt counts RELEASE/RUN/HOLD -> WAIT_LOCK
//                 transitions, saturating at 255, cleared only by rstnn
//     undefined : lock_loss_cnt is tied to zero
// -----------------------------------------------------------------------------
module clock_reset_sequencer #(
   parameter int unsigned NUM_DOMAIN         = 3,
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned LOCK_STABLE_CYCLES = 16,
   parameter int unsigned RELEASE_GAP        = 4,
   parameter int unsigned HOLD_CYCLES        = 8,
   parameter int unsigned CNT_WIDTH          = 16
) (
   input  logic                  clk,
   input  logic                  rstnn,
   input  logic                  pll_locked,
   input  logic                  sw_reset_req,
   output logic [NUM_DOMAIN-1:0] domain_rstnn,
   output logic                  all_released,
   output logic [2:0]            seq_state,
   output logic [7:0]            lock_loss_cnt
);

   localparam int unsigned IDX_W = (NUM_DOMAIN > 1) ? $clog2(NUM_DOMAIN) : 1;

   localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_LAST    = CNT_WIDTH'(RELEASE_GAP - 1);
   localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0]     IDX_LAST    = IDX_W'(NUM_DOMAIN - 1);

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      STABILIZE = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3,
      HOLD      = 3'd4
   } state_t;

   state_t                 state;
   logic [CNT_WIDTH-1:0]   cnt;
   logic [IDX_W-1:0]       idx;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_s;

   // pll_locked is asynchronous; only the last stage of the chain is used.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      end
   end

   assign lock_s    = sync_q[SYNC_STAGES-1];
   assign seq_state = state;

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state        <= WAIT_LOCK;
         cnt          <= '0;
         idx          <= '0;
         domain_rstnn <= '0;
         all_released <= 1'b0;
      end else begin
         case (state)
            WAIT_LOCK: begin
               domain_rstnn <= '0;
               all_released <= 1'b0;
               cnt          <= '0;
               if (lock_s) state <= STABILIZE;
            end

            STABILIZE: begin
               if (!lock_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (sw_reset_req) begin
                  state        <= HOLD;
                  cnt          <= '0;
                  domain_rstnn <= '0;
               end else if (cnt == STABLE_LAST) begin
                  state        <= RELEASE;
                  cnt          <= '0;
                  idx          <= '0;
                  domain_rstnn <= NUM_DOMAIN'(1);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            RELEASE, RUN, HOLD: begin
               // Lock loss outranks a simultaneous software request.
               if (!lock_s) begin
                  state        <= WAIT_LOCK;
                  cnt          <= '0;
                  domain_rstnn <= '0;
                  all_released <= 1'b0;
               end else if (sw_reset_req && state != HOLD) begin
                  state        <= HOLD;
                  cnt          <= '0;
                  domain_rstnn <= '0;
                  all_released <= 1'b0;
               end else if (state == RELEASE) begin
                  if (cnt == GAP_LAST) begin
                     cnt <= '0;
                     if (idx == IDX_LAST) begin
                        state        <= RUN;
                        all_released <= 1'b1;
                     end else begin
                        idx          <= idx + 1'b1;
                        // Shifting a one in keeps release strictly in index order.
                        domain_rstnn <= (domain_rstnn << 1) | NUM_DOMAIN'(1);
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else if (state == HOLD) begin
                  domain_rstnn <= '0;
                  if (cnt == HOLD_LAST) begin
                     // Counter parks here while the request is still held.
                     if (!sw_reset_req) begin
                        state <= STABILIZE;
                        cnt   <= '0;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end

            default: begin
               state        <= WAIT_LOCK;
               cnt          <= '0;
               idx          <= '0;
               domain_rstnn <= '0;
               all_released <= 1'b0;
            end
         endcase
      end
   end

`ifdef CLOCK_RESET_SEQUENCER_LOCK_LOSS_COUNTER_EN
   logic lock_loss_evt;

   assign lock_loss_evt = !lock_s && (state == RELEASE || state == RUN || state == HOLD);

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         lock_loss_cnt <= '0;
      end else if (lock_loss_evt && lock_loss_cnt != 8'hFF) begin
         lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end
   end
`else
   assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_clock_reset_sequencer.sv
module tb_clock_reset_sequencer;

`ifdef CLOCK_RESET_SEQUENCER_LOCK_LOSS_COUNTER_EN
   localparam bit FEAT = 1'b1;
`else
   localparam bit FEAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rstnn;
   logic       pll_locked;
   logic       sw_reset_req;
   logic [2:0] domain_rstnn;
   logic       all_released;
   logic [2:0] seq_state;
   logic [7:0] lock_loss_cnt;

   logic [0:0] d1_rstnn;
   logic       d1_all;
   logic [2:0] d1_state;
   logic [7:0] d1_llc;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   clock_reset_sequencer dut (
      .clk          (clk),
      .rstnn        (rstnn),
      .pll_locked   (pll_locked),
      .sw_reset_req (sw_reset_req),
      .domain_rstnn (domain_rstnn),
      .all_released (all_released),
      .seq_state    (seq_state),
      .lock_loss_cnt(lock_loss_cnt)
   );

   // Single-domain instance with a short gap, driven by the same inputs.
   clock_reset_sequencer #(
      .NUM_DOMAIN  (1),
      .RELEASE_GAP (2)
   ) dut1 (
      .clk          (clk),
      .rstnn        (rstnn),
      .pll_locked   (pll_locked),
      .sw_reset_req (sw_reset_req),
      .domain_rstnn (d1_rstnn),
      .all_released (d1_all),
      .seq_state    (d1_state),
      .lock_loss_cnt(d1_llc)
   );

   typedef struct {
      int         edge_n;  // edge index counted from first sample of pll_locked=1
      logic [2:0] st;
      logic [2:0] rst;
      logic       all;
      logic       rst1;
      logic       all1;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_main(input string tag, input logic [2:0] st, input logic [2:0] rst,
                           input logic all);
      chk({tag, ".state"}, 32'(seq_state), 32'(st));
      chk({tag, ".rst"},   32'(domain_rstnn), 32'(rst));
      chk({tag, ".all"},   32'(all_released), 32'(all));
   endtask

   function automatic logic [7:0] exp_llc(input int n);
      if (!FEAT) return 8'd0;
      return (n > 255) ? 8'd255 : 8'(n);
   endfunction

   // Walks the release table for entries in (cur, last]; caller sits #1 after edge 'cur'.
   task automatic run_table(input string tag, input int cur, input int last);
      int c = cur;
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].edge_n > c && tbl[i].edge_n <= last) begin
            repeat (tbl[i].edge_n - c) @(posedge clk);
            #1;
            c = tbl[i].edge_n;
            chk_main($sformatf("%s.E%0d", tag, c), tbl[i].st, tbl[i].rst, tbl[i].all);
            chk($sformatf("%s.E%0d.d1rst", tag, c), 32'(d1_rstnn), 32'(tbl[i].rst1));
            chk($sformatf("%s.E%0d.d1all", tag, c), 32'(d1_all), 32'(tbl[i].all1));
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{0,  3'd0, 3'b000, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1,  3'd0, 3'b000, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{2,  3'd1, 3'b000, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{10, 3'd1, 3'b000, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{17, 3'd1, 3'b000, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{18, 3'd2, 3'b001, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{19, 3'd2, 3'b001, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{20, 3'd2, 3'b001, 1'b0, 1'b1, 1'b1};
      tbl[8]  = '{21, 3'd2, 3'b001, 1'b0, 1'b1, 1'b1};
      tbl[9]  = '{22, 3'd2, 3'b011, 1'b0, 1'b1, 1'b1};
      tbl[10] = '{25, 3'd2, 3'b011, 1'b0, 1'b1, 1'b1};
      tbl[11] = '{26, 3'd2, 3'b111, 1'b0, 1'b1, 1'b1};
      tbl[12] = '{29, 3'd2, 3'b111, 1'b0, 1'b1, 1'b1};
      tbl[13] = '{30, 3'd3, 3'b111, 1'b1, 1'b1, 1'b1};

      // Reset state, checked before any clock edge.
      rstnn = 1'b0; pll_locked = 1'b0; sw_reset_req = 1'b0;
      #2;
      chk_main("reset", 3'd0, 3'b000, 1'b0);
      chk("reset.llc", 32'(lock_loss_cnt), 32'(0));
      step(3);
      rstnn = 1'b1;
      step(2);
      chk_main("idle", 3'd0, 3'b000, 1'b0);

      // Power-up release sequence.
      pll_locked = 1'b1;
      run_table("pwr", -1, 30);

      // Lock loss in RUN: outputs drop SYNC_STAGES+1 edges after the drop.
      pll_locked = 1'b0;
      step(2);
      chk_main("loss.e2", 3'd3, 3'b111, 1'b1);
      step(1);
      chk_main("loss.e3", 3'd0, 3'b000, 1'b0);
      chk("loss.llc", 32'(lock_loss_cnt), 32'(exp_llc(1)));
      step(1);

      // Lock glitch during STABILIZE: high for 10 cycles, then low.
      pll_locked = 1'b1;
      step(10);
      pll_locked = 1'b0;
      step(2);
      chk_main("glitch.e11", 3'd1, 3'b000, 1'b0);
      step(1);
      chk_main("glitch.e12", 3'd0, 3'b000, 1'b0);
      chk("glitch.llc", 32'(lock_loss_cnt), 32'(exp_llc(1)));
      pll_locked = 1'b1;
      run_table("relock", -1, 30);

      // One-cycle software reset in RUN.
      sw_reset_req = 1'b1;
      step(1);
      sw_reset_req = 1'b0;
      chk_main("sw.s1", 3'd4, 3'b000, 1'b0);
      chk("sw.s1.d1rst", 32'(d1_rstnn), 32'(0));
      step(7);
      chk_main("sw.s8", 3'd4, 3'b000, 1'b0);
      step(1);
      chk_main("sw.s9", 3'd1, 3'b000, 1'b0);
      run_table("swrel", 2, 30);

      // Held software reset: HOLD persists past the hold time, then re-qualifies.
      sw_reset_req = 1'b1;
      step(12);
      chk_main("swheld.s12", 3'd4, 3'b000, 1'b0);
      sw_reset_req = 1'b0;
      step(1);
      chk_main("swheld.s13", 3'd1, 3'b000, 1'b0);
      run_table("swheld", 2, 30);

      // Simultaneous lock loss and sw request while idx=1.
      pll_locked = 1'b0;
      step(3);
      pll_locked = 1'b1;
      run_table("sim", -1, 22);
      pll_locked = 1'b0;
      step(2);
      chk_main("sim.e24", 3'd2, 3'b011, 1'b0);
      sw_reset_req = 1'b1;
      step(1);
      sw_reset_req = 1'b0;
      chk_main("sim.e25", 3'd0, 3'b000, 1'b0);
      chk("sim.llc", 32'(lock_loss_cnt), 32'(exp_llc(3)));
      step(2);

      // Asynchronous reset mid-release, observed between clock edges.
      pll_locked = 1'b1;
      run_table("async", -1, 22);
      step(1);
      #2;
      rstnn = 1'b0;
      #1;
      chk_main("async", 3'd0, 3'b000, 1'b0);
      chk("async.llc", 32'(lock_loss_cnt), 32'(0));
      chk("async.d1rst", 32'(d1_rstnn), 32'(0));
      pll_locked = 1'b0;
      step(2);
      rstnn = 1'b1;
      step(2);

      // Repeated lock losses from RELEASE: counter saturates.
      for (int i = 1; i <= 300; i++) begin
         pll_locked = 1'b1;
         step(20);
         pll_locked = 1'b0;
         step(4);
         if (i == 1 || i == 254 || i == 255 || i == 300)
            chk($sformatf("sat.%0d", i), 32'(lock_loss_cnt), 32'(exp_llc(i)));
      end
      chk_main("sat.end", 3'd0, 3'b000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/clock_reset_sequencer.md
Name: clock_reset_sequencer

Overview:
- Sequences reset release for the clock domains generated by the platform clock/PLL block.
- Holds every downstream domain in reset until the PLL lock indication is synchronized and stable, then releases the domain resets one by one in a fixed order with a programmable gap.
- Re-asserts all domain resets on loss of lock or on a software reset request.
- Sits between the clock/PLL block and the system, DRAM-sys and DRAM-ref reset trees.

Parameters:
- NUM_DOMAIN, 3, number of sequenced reset outputs; domain 0 is released first.
- SYNC_STAGES, 2, synchronizer depth for pll_locked (minimum 2).
- LOCK_STABLE_CYCLES, 16, consecutive synchronized-lock cycles required before release (minimum 1).
- RELEASE_GAP, 4, cycles between successive domain releases (minimum 1).
- HOLD_CYCLES, 8, cycles all resets stay asserted after sw_reset_req (minimum 1).
- CNT_WIDTH, 16, width of the internal counter; must hold max(LOCK_STABLE_CYCLES, RELEASE_GAP, HOLD_CYCLES).

Ports:
- clk  input  1  sequencer clock (free-running reference clock).
- rstnn  input  1  asynchronous active-low reset.
- pll_locked  input  1  PLL lock; asynchronous to clk.
- sw_reset_req  input  1  level request for a full domain reset, synchronous to clk.
- domain_rstnn  output  NUM_DOMAIN  per-domain active-low reset, registered.
- all_released  output  1  high when in RUN.
- seq_state  output  3  current FSM state encoding, for debug.
- lock_loss_cnt  output  8  saturating lock-loss event count (optional feature).

Behaviour:
- Reset (rstnn=0, asynchronous):
  - synchronizer flops=0, state=WAIT_LOCK, counter=0, idx=0.
  - domain_rstnn=all 0, all_released=0, lock_loss_cnt=0.
- lock_s is the SYNC_STAGES-deep flop chain output of pll_locked. Latency from pll_locked to lock_s is SYNC_STAGES edges.
- Encodings: WAIT_LOCK=0, STABILIZE=1, RELEASE=2, RUN=3, HOLD=4.
- WAIT_LOCK:
  - domain_rstnn all 0, counter=0.
  - lock_s=1 -> STABILIZE.
- STABILIZE:
  - counter increments each cycle.
  - lock_s=0 -> WAIT_LOCK, counter cleared.
  - counter==LOCK_STABLE_CYCLES-1 with lock_s=1 -> RELEASE. On that same edge: domain_rstnn[0]=1, idx=0, counter=0.
- RELEASE:
  - counter increments each cycle.
  - counter==RELEASE_GAP-1 -> idx+1, domain_rstnn[idx+1]=1, counter=0.
  - Once the last domain has been released, the next counter==RELEASE_GAP-1 goes to RUN; all_released=1 from that edge.
- RUN: outputs held.
- HOLD:
  - domain_rstnn all 0, counter increments.
  - counter==HOLD_CYCLES-1 and sw_reset_req=0 -> STABILIZE with counter=0 (lock re-qualified).
  - If sw_reset_req is still 1, stay in HOLD with counter saturated.
- Lock loss: lock_s=0 in RELEASE, RUN or HOLD -> WAIT_LOCK on the next edge. All domain_rstnn=0 and all_released=0 on that edge.
- sw_reset_req=1 in STABILIZE, RELEASE or RUN -> HOLD, all resets 0 and counter=0 on the next edge. In WAIT_LOCK it is ignored.
- Simultaneous lock loss and sw_reset_req: lock loss wins (WAIT_LOCK).
- Resets only assert in bulk. Release is strictly ordered 0..NUM_DOMAIN-1; a domain is never released before a lower-indexed one.
- All outputs are driven straight from flops (no combinational glitches on reset nets).
- NUM_DOMAIN=1: RELEASE waits RELEASE_GAP cycles, then goes to RUN.

Optional Feature:
- CLOCK_RESET_SEQUENCER_LOCK_LOSS_COUNTER_EN
- Defined: lock_loss_cnt increments by 1 on each lock-loss transition (RELEASE/RUN/HOLD -> WAIT_LOCK). It saturates at 255 and clears only on rstnn.
- Undefined: no counter logic; lock_loss_cnt tied to 0.

Test Plan:
- Power-up: rstnn low, then high; pll_locked rises, first sampled at edge E0 (defaults) -> STABILIZE after E2, domain_rstnn[0]=1 after E18, [1] after E22, [2] after E26, all_released=1 after E30.
- Lock glitch: pll_locked high 10 cycles then low during STABILIZE -> returns to WAIT_LOCK, no domain released; next stable lock reproduces the power-up timing.
- Lock loss in RUN: drop pll_locked -> domain_rstnn=000 and all_released=0 exactly SYNC_STAGES+1 edges later. With the feature enabled, lock_loss_cnt=1.
- sw_reset in RUN: 1-cycle sw_reset_req pulse -> resets 000 next edge, HOLD for 8 cycles, STABILIZE 16 cycles, then the ordered release resumes.
- Simultaneous events: lock loss and sw_reset_req in the same cycle during RELEASE (idx=1) -> WAIT_LOCK, not HOLD.
- Mid-sequence async reset: assert rstnn during RELEASE -> all outputs 0 immediately, without waiting for a clock edge; state=WAIT_LOCK. Repeat 300 lock losses with the feature on -> lock_loss_cnt=255.
